// File: rtl/cbd_pkg.sv
// Shared constants, FSM state type and lane helper for the CBD (eta=3) polynomial scheduler.
//
// Contents:
//   WORD_W / GROUP_W / COEFF_W  - XOF word, CBD input group and coefficient widths
//   WORDS_PER_POLY / GROUPS_PER_POLY - stream shape of one 256-coefficient polynomial
//   BUF_W / CNT_W               - gearbox buffer width and bit-count width
//   state_e                     - scheduler FSM states
//   mod_q_lane()                - maps a negative two's-complement lane x to q + x
package cbd_pkg;

    localparam int unsigned WORD_W          = 64;
    localparam int unsigned GROUP_W         = 24;
    localparam int unsigned COEFF_W         = 12;
    localparam int unsigned LANES           = 4;
    localparam int unsigned WORDS_PER_POLY  = 24;
    localparam int unsigned GROUPS_PER_POLY = 64;
    localparam int unsigned BUF_W           = 96;
    localparam int unsigned CNT_W           = 7;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StStream,
        StDrain,
        StNext,
        StFin
    } state_e;

    // Lane values are limited to -3..3, so q + x never leaves the 12-bit range.
    function automatic logic [COEFF_W-1:0] mod_q_lane(input logic [COEFF_W-1:0] x,
                                                      input logic [COEFF_W-1:0] q);
        if (x[COEFF_W-1]) begin
            return q + x;
        end
        return x;
    endfunction

endpackage

// File: rtl/cbd_gearbox_64to24.sv
// 64-bit to 24-bit gearbox between the XOF word stream and the CBD sampling unit.
//
// Ports:
//   clk_i, reset_i      - clock, synchronous active-high reset
//   clear_i             - empties the buffer and word counter (start of a polynomial)
//   take_en_i           - word acceptance allowed (scheduler in STREAM)
//   active_i            - group consumption allowed (scheduler in STREAM or DRAIN)
//   xof_valid_i/_data_i - incoming XOF word, bit 0 consumed first
//   xof_ready_o         - word accepted when xof_valid_i & xof_ready_o
//   consume_o           - one 24-bit group is handed to the CBD unit this cycle
//   cbd_bits_o          - current group; holds the last group when nothing is consumed
//   count_o             - valid bits currently buffered
//   words_taken_o       - words accepted since the last clear
module cbd_gearbox_64to24
    import cbd_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                clear_i,
    input  logic                take_en_i,
    input  logic                active_i,
    input  logic                xof_valid_i,
    input  logic [WORD_W-1:0]   xof_data_i,
    output logic                xof_ready_o,
    output logic                consume_o,
    output logic [GROUP_W-1:0]  cbd_bits_o,
    output logic [CNT_W-1:0]    count_o,
    output logic [4:0]          words_taken_o
);

    localparam logic [CNT_W-1:0] CntGroup = CNT_W'(GROUP_W);
    localparam logic [CNT_W-1:0] CntWord  = CNT_W'(WORD_W);
    // A word fits only if 64 more bits stay inside the 96-bit buffer.
    localparam logic [CNT_W-1:0] CntRoom  = CNT_W'(BUF_W - WORD_W);
    localparam logic [4:0]       WordsMax = 5'(WORDS_PER_POLY);

    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         words_q, words_d;
    logic [GROUP_W-1:0] bits_q;
    logic [CNT_W-1:0]   shamt;
    logic               accept;

    assign xof_ready_o   = take_en_i && (cnt_q <= CntRoom) && (words_q < WordsMax);
    assign accept        = xof_valid_i && xof_ready_o;
    assign consume_o     = active_i && (cnt_q >= CntGroup);
    assign cbd_bits_o    = consume_o ? buf_q[GROUP_W-1:0] : bits_q;
    assign count_o       = cnt_q;
    assign words_taken_o = words_q;

    always_comb begin
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        shamt   = cnt_q;
        if (consume_o) begin
            buf_d = buf_q >> GROUP_W;
            cnt_d = cnt_q - CntGroup;
            shamt = cnt_q - CntGroup;
        end
        // Bits above count are always zero, so an OR places the new word behind the old bits.
        if (accept) begin
            buf_d   = buf_d | ({{(BUF_W - WORD_W){1'b0}}, xof_data_i} << shamt);
            cnt_d   = cnt_d + CntWord;
            words_d = words_q + 5'd1;
        end
        if (clear_i) begin
            buf_d   = '0;
            cnt_d   = '0;
            words_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            words_q <= '0;
            bits_q  <= '0;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            if (consume_o) begin
                bits_q <= buf_q[GROUP_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cbd_poly_scheduler.sv
// Sequences centered-binomial (eta=3) sampling of NUM_POLY polynomials of 256 coefficients.
// For each polynomial a new XOF stream is requested with nonce NONCE_BASE+poly, 24 words are
// taken, cut into 64 groups of 24 bits for the external combinational CBD unit, and the four
// returned coefficients are written to coefficient memory one cycle after each group.
//
// Optional build macro MOD_Q_EN: negative lanes are written as Q+x, adding one write stage.
//
// Ports:
//   clk_i, reset_i           - clock, synchronous active-high reset (aborts a run)
//   start_i, busy_o, done_o  - run control; done_o pulses after the last memory write
//   hash_start_o/_nonce_o    - one-cycle XOF stream request and its nonce
//   xof_valid_i/_data_i/_ready_o - XOF word handshake
//   cbd_bits_o, cbd_coeffs_i - group to the CBD unit and its 4 x 12-bit result
//   mem_we_o/_addr_o/_wdata_o - coefficient write port, addr = {poly, group}
module cbd_poly_scheduler
    import cbd_pkg::*;
#(
    parameter int unsigned NUM_POLY   = 3,
    parameter logic [7:0]  NONCE_BASE = 8'h00,
    parameter int unsigned Q          = 3329
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       hash_start_o,
    output logic [7:0]                 hash_nonce_o,
    input  logic                       xof_valid_i,
    input  logic [WORD_W-1:0]          xof_data_i,
    output logic                       xof_ready_o,
    output logic [GROUP_W-1:0]         cbd_bits_o,
    input  logic [LANES*COEFF_W-1:0]   cbd_coeffs_i,
    output logic                       mem_we_o,
    output logic [7:0]                 mem_addr_o,
    output logic [LANES*COEFF_W-1:0]   mem_wdata_o
);

    localparam logic [1:0] LastPoly  = 2'(NUM_POLY - 1);
    localparam logic [4:0] WordsMax  = 5'(WORDS_PER_POLY);
    localparam logic [6:0] GroupLast = 7'(GROUPS_PER_POLY - 1);

    state_e                   state_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     hash_start_q;
    logic [7:0]               hash_nonce_q;
    logic [1:0]               poly_q;
    logic [6:0]               grp_q;

    logic                     consume;
    logic [CNT_W-1:0]         gb_count;
    logic [4:0]               words_taken;
    logic                     drain_done;

    logic                     mem_we_q;
    logic [7:0]               mem_addr_q;
    logic [LANES*COEFF_W-1:0] mem_wdata_q;

    cbd_gearbox_64to24 u_gearbox (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .clear_i       (state_q == StReq),
        .take_en_i     (state_q == StStream),
        .active_i      ((state_q == StStream) || (state_q == StDrain)),
        .xof_valid_i   (xof_valid_i),
        .xof_data_i    (xof_data_i),
        .xof_ready_o   (xof_ready_o),
        .consume_o     (consume),
        .cbd_bits_o    (cbd_bits_o),
        .count_o       (gb_count),
        .words_taken_o (words_taken)
    );

    // Leave DRAIN so that FIN (and done) lands exactly one cycle after the final write.
`ifdef MOD_Q_EN
    assign drain_done = (grp_q == 7'(GROUPS_PER_POLY));
`else
    assign drain_done = consume && (grp_q == GroupLast);
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hash_start_q <= 1'b0;
            hash_nonce_q <= NONCE_BASE;
            poly_q       <= '0;
            grp_q        <= '0;
        end else begin
            done_q       <= 1'b0;
            hash_start_q <= 1'b0;
            if (consume) begin
                grp_q <= grp_q + 7'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q      <= StReq;
                        busy_q       <= 1'b1;
                        hash_start_q <= 1'b1;
                        hash_nonce_q <= NONCE_BASE;
                        poly_q       <= '0;
                        grp_q        <= '0;
                    end
                end
                StReq: begin
                    state_q <= StStream;
                end
                StStream: begin
                    if (words_taken == WordsMax) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_done) begin
                        state_q <= StNext;
                    end
                end
                StNext: begin
                    grp_q  <= '0;
                    poly_q <= poly_q + 2'd1;
                    if (poly_q == LastPoly) begin
                        state_q <= StFin;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q      <= StReq;
                        hash_start_q <= 1'b1;
                        hash_nonce_q <= NONCE_BASE + 8'(poly_q) + 8'd1;
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef MOD_Q_EN
    localparam logic [COEFF_W-1:0] QLane = COEFF_W'(Q);

    logic                     s1_we_q;
    logic [7:0]               s1_addr_q;
    logic [LANES*COEFF_W-1:0] s1_data_q;
    logic [LANES*COEFF_W-1:0] s1_mapped;

    always_comb begin
        s1_mapped = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            s1_mapped[i*COEFF_W +: COEFF_W] = mod_q_lane(s1_data_q[i*COEFF_W +: COEFF_W], QLane);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_we_q     <= 1'b0;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            s1_we_q  <= consume;
            mem_we_q <= s1_we_q;
            if (consume) begin
                s1_addr_q <= {poly_q, grp_q[5:0]};
                s1_data_q <= cbd_coeffs_i;
            end
            if (s1_we_q) begin
                mem_addr_q  <= s1_addr_q;
                mem_wdata_q <= s1_mapped;
            end
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= consume;
            if (consume) begin
                mem_addr_q  <= {poly_q, grp_q[5:0]};
                mem_wdata_q <= cbd_coeffs_i;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // 24 words x 64 bits equals 64 groups x 24 bits, so every polynomial must end empty.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            assert (NUM_POLY >= 1 && NUM_POLY <= 4 && Q < 4096)
            else $error("cbd_poly_scheduler: parameter out of range");
        end else if (state_q == StNext) begin
            assert (gb_count == '0)
            else $error("cbd_poly_scheduler: gearbox not empty at end of polynomial");
        end
    end
`endif

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign hash_start_o = hash_start_q;
    assign hash_nonce_o = hash_nonce_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: doc/cbd_poly_scheduler.md
Name: cbd_poly_scheduler

Overview:
Sequences centered-binomial (eta=3) sampling of NUM_POLY polynomials of 256 coefficients each. For each polynomial it starts the PRF/XOF hash with a per-polynomial nonce and accepts 64-bit XOF words over a valid/ready handshake. A 64-to-24-bit gearbox feeds the external combinational CBD unit, and the 4 resulting 12-bit coefficients are written per cycle into coefficient memory. The block sits between the hash core, the CBD sampling unit and the polynomial RAM.

Parameters:
NUM_POLY, 3, polynomials per run (K); 1..4
NONCE_BASE, 0, nonce of polynomial 0; polynomial p uses NONCE_BASE+p (8-bit, wraps)
Q, 3329, modulus used by MOD_Q_EN

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a run; sampled in IDLE only
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse after the last memory write
hash_start  out  1  one-cycle pulse requesting a new XOF stream
hash_nonce  out  8  nonce; valid while hash_start is high
xof_valid  in  1  xof_data valid
xof_data  in  64  XOF word, bit 0 consumed first
xof_ready  out  1  word accepted when xof_valid & xof_ready
cbd_bits  out  24  current 24-bit group to the CBD unit
cbd_coeffs  in  48  4 x 12-bit two's-complement coeffs (lane i = bits 12i+11:12i), range -3..3
mem_we  out  1  coefficient write strobe
mem_addr  out  8  {poly[1:0], group[5:0]}
mem_wdata  out  48  4 coefficients, lane 0 = lowest index

Behaviour:
- Reset: state IDLE; busy, done, hash_start, xof_ready and mem_we = 0; mem_addr and mem_wdata = 0; hash_nonce = NONCE_BASE; buffer count, word counter, group counter and poly counter = 0. Reset mid-run aborts the run with no done pulse and discards buffered bits.
- FSM states: IDLE, REQ, STREAM, DRAIN, NEXT, FIN.
- IDLE: on start go to REQ and set busy. start while busy is ignored.
- REQ: hash_start=1 for one cycle with nonce NONCE_BASE+poly; then go to STREAM.
- STREAM: gearbox has a 96-bit buffer and a 7-bit count (0..87). xof_ready = (count <= 32) & (words_taken < 24). An accepted word is appended at bit position count. When count >= 24, the low 24 bits drive cbd_bits and one group is consumed (buffer >> 24, count -= 24). Accept and consume may happen in the same cycle; count_next = count + 64·acc − 24·cons. After 24 words go to DRAIN.
- DRAIN: continue consuming groups until 64 groups are done. 24·64 = 1536 bits, so count is exactly 0 afterwards; a non-zero count is a checked assertion failure. Then go to NEXT.
- NEXT: poly+1. If poly == NUM_POLY−1 go to FIN, else go to REQ.
- FIN: done=1 for one cycle, busy=0, go to IDLE. The last mem_we occurs in the cycle before done.
- Write latency: the group consumed in cycle t is written in cycle t+1: mem_we=1, mem_addr={poly,group}, mem_wdata = registered cbd_coeffs. Group order is strictly 0..63.
- cbd_bits holds its last value when no group is consumed. xof_ready is 0 outside STREAM.
- xof_valid while xof_ready=0 is not accepted and produces no side effect.

Optional Feature:
MOD_Q_EN
- Defined: each negative lane x is written as Q+x (−1→3328, −3→3326); non-negative lanes pass unchanged. This adds one cycle of write latency: write occurs in t+2, and done shifts by one cycle.
- Undefined: lanes are written as raw 12-bit two's complement (−3 → 0xFFD).

Decomposition:
- Package cbd_pkg: WORD_W=64, GROUP_W=24, COEFF_W=12, WORDS_PER_POLY=24, GROUPS_PER_POLY=64, BUF_W=96, state enum.
- Sub-module cbd_gearbox_64to24: buffer, count, accept/consume logic, words_taken. The FSM, counters and the memory write stage stay in the top.

Test Plan:
- NUM_POLY=1, continuous xof_valid, all words 0 -> 64 writes, mem_addr 0..63, all mem_wdata 0; done pulses once; 24 words accepted.
- Word 0 = 64'h0000_0000_0000_0007 -> group 0 lane 0 = +3 (0x003). Word 0 = 64'h38 -> lane 0 = 0xFFD, or 3326 with MOD_Q_EN.
- NUM_POLY=3, NONCE_BASE=8'hFF -> hash_start pulses carry nonces FF, 00, 01; mem_addr ranges 0–63, 64–127, 128–191.
- Random xof_valid gaps (~50%) -> write stream identical to the gapless run; xof_ready never high while count > 32.
- reset asserted at group 30 of poly 1, then start -> no done from the aborted run; the new run begins at poly 0, addr 0, nonce NONCE_BASE.
- start pulsed during STREAM -> ignored; exactly NUM_POLY·64 writes and one done.
